mips_16_id_stage: RTL
=====================

Name: mips_16_id_stage

Overview:
- Instruction-decode pipeline stage for mips_16; it produces the `a`/`b`/`cmd` operand bundle that the combinational ALU in EX consumes.
- Accepts one 16-bit instruction per cycle from IF over a valid/ready handshake and decodes the opcode into an ALU command plus memory/writeback/branch controls.
- Reads the register file through two combinational read ports and registers the full bundle into the ID/EX pipeline register.
- Detects load-use hazards, inserts bubbles, honours downstream stall and branch flush.

Parameters:
- PC_W, 16, width of instruction address carried with each instruction.
- REG_AW, 3, register-file address width (8 registers, R0 hard-wired zero).

Ports:
- clk  in  1  stage clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  IF presents instruction
- in_ready  out  1  ID accepts instruction this cycle
- in_instr  in  16  instruction word
- in_pc  in  PC_W  instruction address
- flush  in  1  branch taken in EX; kill in-flight/incoming instruction
- rf_raddr1  out  REG_AW  register-file read address, port 1 (rs)
- rf_raddr2  out  REG_AW  register-file read address, port 2 (rt, or rd for SW)
- rf_rdata1  in  16  read data, port 1 (combinational)
- rf_rdata2  in  16  read data, port 2 (combinational)
- ex_valid  out  1  ID/EX register holds a live instruction
- ex_ready  in  1  EX consumes bundle this cycle
- ex_alu_cmd  out  3  ALU function select, ALU_* code
- ex_a  out  16  ALU src1
- ex_b  out  16  ALU src2
- ex_store_data  out  16  SW data
- ex_wb_en  out  1  write result to register file
- ex_wb_addr  out  REG_AW  destination register
- ex_mem_rd  out  1  LW
- ex_mem_wr  out  1  SW
- ex_branch  out  1  BZ; EX tests ex_a==0
- ex_pc  out  PC_W  pc of bundle
- illegal_op  out  1  one-cycle pulse when an undefined opcode is accepted

Behaviour:
- Instruction format:
  - op = [15:12], rd = [11:9], rs = [8:6], rt = [5:3].
  - imm6 = [5:0], sign-extended to 16 bits.
- Opcode decode:
  - 0 NOP: cmd ALU_NC, no wb.
  - 1–7 R-type ADD, SUB, AND, OR, XOR, SL, SR: a = R[rs], b = R[rt], wb to rd.
  - 8 ADDI: ALU_ADD, b = sext(imm6), wb to rd.
  - 9 LW: ALU_ADD, a = R[rs], b = sext(imm6), mem_rd, wb to rd.
  - 10 SW: ALU_ADD, a = R[rs], b = sext(imm6), store_data = R[rd], mem_wr, no wb.
  - 11 BZ: ALU_ADD, a = R[rd], b = sext(imm6), branch, no wb.
  - 12–15 illegal: decoded as NOP, illegal_op pulses in the accept cycle.
- Register addressing:
  - Address 0 always yields 0 in ex_a/ex_b/ex_store_data, regardless of rf_rdata.
  - wb_en is forced 0 when rd = 0.
- rf_raddr1 = rs, except BZ uses rd. rf_raddr2 = rt for R-type; rd for SW. Both are combinational from in_instr.
- Handshake:
  - hazard = ex_valid & ex_mem_rd & in_valid & (instruction reads ex_wb_addr through a used source field).
  - in_ready = (~ex_valid | ex_ready) & ~hazard & ~flush.
  - Accept = in_valid & in_ready; latency is 1 cycle from accept to ex_valid.
- ID/EX register update priority, each clock:
  1. flush: ex_valid <= 0; incoming instruction dropped.
  2. ex_valid & ~ex_ready: hold all ex_* unchanged.
  3. hazard: ex_valid <= 0 (bubble); instruction stays at input.
  4. accept: load decoded bundle, ex_valid <= 1.
  5. else: ex_valid <= 0.
- Bubble/NOP contents: ex_wb_en, ex_mem_rd, ex_mem_wr, ex_branch are 0 whenever ex_valid = 0.
- Reset (async, rst_n low, including mid-stall):
  - All ex_* outputs 0; ex_alu_cmd = ALU_NC; illegal_op = 0.
  - in_ready is low while rst_n is low.
- Forwarding from EX/MEM is out of scope; the register file is write-before-read.

Decomposition:
- Shared defs file (extended):
  - ALU_* command codes.
  - New OP_* opcode constants (4 bits).
  - Field bit positions.
- Sub-module mips_16_id_decode: pure combinational opcode-to-control decode, including source-usage flags for the hazard compare. The top handles the handshake, hazard and pipeline register.

Test Plan:
- Reset: rst_n low mid-stream with ex_valid = 1 → all ex_* = 0, cmd = ALU_NC, within the same cycle (async).
- ADD R3,R1,R2 with rf_rdata = 0x0005/0x0007, ex_ready = 1 → next cycle ex_valid = 1, cmd = ALU_ADD, a = 5, b = 7, wb_en = 1, wb_addr = 3.
- ADDI R1,R0,-1 (imm6 = 0x3F) → a = 0x0000, b = 0xFFFF, even if rf_rdata1 = 0x1234.
- LW R2,0(R1) followed by ADD R4,R2,R2 → one bubble cycle (in_ready = 0, ex_valid = 0), then the ADD is issued. With ADD R4,R1,R1 instead → no bubble.
- ex_ready = 0 for 3 cycles with in_valid = 1 → ex_* stable, in_ready = 0; on release the next instruction is accepted in the same cycle.
- flush asserted during a stall, and separately an op = 13 instruction → ex_valid = 0 next cycle; illegal_op pulses one cycle, bundle is a NOP.

Source files
------------

// File: rtl/mips_16_id_stage_pkg.sv
// Shared definitions for the mips_16 decode stage.
// Holds the ALU command encoding consumed by EX, the 4-bit opcode map,
// instruction field bit positions and small decode helpers.
package mips_16_id_stage_pkg;

  // ALU function select carried in ex_alu_cmd
  typedef enum logic [2:0] {
    ALU_NC  = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5,
    ALU_SL  = 3'd6,
    ALU_SR  = 3'd7
  } alu_cmd_e;

  // Opcode map; 12..15 are undefined
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SL   = 4'd6;
  localparam logic [3:0] OP_SR   = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_LW   = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;
  localparam logic [3:0] OP_BZ   = 4'd11;

  // Instruction field positions
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS_HI  = 8;
  localparam int RS_LO  = 6;
  localparam int RT_HI  = 5;
  localparam int RT_LO  = 3;
  localparam int IMM_HI = 5;
  localparam int IMM_LO = 0;

  // Width of a register field inside the instruction word
  localparam int FIELD_W = 3;

  // Sign-extend the 6-bit immediate to a 16-bit operand
  function automatic logic [15:0] sext6(input logic [5:0] imm);
    return {{10{imm[5]}}, imm};
  endfunction

  // Map an R-type opcode to its ALU command
  function automatic alu_cmd_e rtype_cmd(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_SL:   return ALU_SL;
      OP_SR:   return ALU_SR;
      default: return ALU_NC;
    endcase
  endfunction

endpackage

// File: rtl/mips_16_id_decode.sv
// Pure combinational opcode decode for the mips_16 ID stage.
// Ports:
//   instr    - instruction word from IF
//   alu_cmd  - ALU function select
//   raddr1/2 - register-file read addresses (port 1 = rs or rd for BZ,
//              port 2 = rt or rd for SW)
//   rd       - destination field
//   use1/2   - the corresponding read port feeds a live operand
//              (used by the load-use hazard compare)
//   b_imm    - src2 is the sign-extended immediate
//   wb, mem_rd, mem_wr, branch - raw control flags (wb not yet masked for R0)
//   illegal  - opcode is undefined
//   imm      - sign-extended imm6
module mips_16_id_decode
  import mips_16_id_stage_pkg::*;
(
  input  logic [15:0]        instr,
  output logic [2:0]         alu_cmd,
  output logic [FIELD_W-1:0] raddr1,
  output logic [FIELD_W-1:0] raddr2,
  output logic [FIELD_W-1:0] rd,
  output logic               use1,
  output logic               use2,
  output logic               b_imm,
  output logic               wb,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               branch,
  output logic               illegal,
  output logic [15:0]        imm
);

  logic [3:0]         op_s;
  logic [FIELD_W-1:0] rs_s;
  logic [FIELD_W-1:0] rt_s;

  assign op_s = instr[OP_HI:OP_LO];
  assign rd   = instr[RD_HI:RD_LO];
  assign rs_s = instr[RS_HI:RS_LO];
  assign rt_s = instr[RT_HI:RT_LO];
  assign imm  = sext6(instr[IMM_HI:IMM_LO]);

  // Opcode to control-flag decode; undefined opcodes decode as NOP
  always_comb begin
    alu_cmd = ALU_NC;
    raddr1  = rs_s;
    raddr2  = rt_s;
    use1    = 1'b0;
    use2    = 1'b0;
    b_imm   = 1'b0;
    wb      = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    branch  = 1'b0;
    illegal = 1'b0;
    case (op_s)
      OP_NOP: begin
        alu_cmd = ALU_NC;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SL, OP_SR: begin
        alu_cmd = rtype_cmd(op_s);
        use1    = 1'b1;
        use2    = 1'b1;
        wb      = 1'b1;
      end
      OP_ADDI: begin
        alu_cmd = ALU_ADD;
        use1    = 1'b1;
        b_imm   = 1'b1;
        wb      = 1'b1;
      end
      OP_LW: begin
        alu_cmd = ALU_ADD;
        use1    = 1'b1;
        b_imm   = 1'b1;
        mem_rd  = 1'b1;
        wb      = 1'b1;
      end
      OP_SW: begin
        // port 2 carries the store data from rd
        alu_cmd = ALU_ADD;
        raddr2  = rd;
        use1    = 1'b1;
        use2    = 1'b1;
        b_imm   = 1'b1;
        mem_wr  = 1'b1;
      end
      OP_BZ: begin
        // the tested register rd is read through port 1
        alu_cmd = ALU_ADD;
        raddr1  = rd;
        use1    = 1'b1;
        b_imm   = 1'b1;
        branch  = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mips_16_id_stage.sv
// mips_16 instruction-decode pipeline stage.
// Takes one instruction per cycle from IF (in_valid/in_ready), reads the
// register file through two combinational ports and registers the operand
// and control bundle into the ID/EX register (ex_valid/ex_ready).
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   in_valid/in_ready       - IF handshake; in_instr, in_pc payload
//   flush                   - branch taken in EX, kills in-flight/incoming op
//   rf_raddr1/2, rf_rdata1/2 - register-file read ports
//   ex_*                    - registered ID/EX bundle with ex_valid/ex_ready
//   illegal_op              - pulses while an undefined opcode is accepted
module mips_16_id_stage
  import mips_16_id_stage_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [15:0]       rf_rdata1,
  input  logic [15:0]       rf_rdata2,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [2:0]        ex_alu_cmd,
  output logic [15:0]       ex_a,
  output logic [15:0]       ex_b,
  output logic [15:0]       ex_store_data,
  output logic              ex_wb_en,
  output logic [REG_AW-1:0] ex_wb_addr,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic              ex_branch,
  output logic [PC_W-1:0]   ex_pc,
  output logic              illegal_op
);

  logic [2:0]         alu_cmd_s;
  logic [FIELD_W-1:0] raddr1_s;
  logic [FIELD_W-1:0] raddr2_s;
  logic [FIELD_W-1:0] rd_s;
  logic               use1_s;
  logic               use2_s;
  logic               b_imm_s;
  logic               wb_s;
  logic               mem_rd_s;
  logic               mem_wr_s;
  logic               branch_s;
  logic               illegal_s;
  logic [15:0]        imm_s;

  logic               hazard_s;
  logic               ready_s;
  logic               accept_s;
  logic               hold_s;
  logic               load_s;
  logic               clear_s;
  logic [15:0]        a_s;
  logic [15:0]        b_s;
  logic [15:0]        sd_s;
  logic               wb_en_s;

  mips_16_id_decode u_decode (
    .instr   (in_instr),
    .alu_cmd (alu_cmd_s),
    .raddr1  (raddr1_s),
    .raddr2  (raddr2_s),
    .rd      (rd_s),
    .use1    (use1_s),
    .use2    (use2_s),
    .b_imm   (b_imm_s),
    .wb      (wb_s),
    .mem_rd  (mem_rd_s),
    .mem_wr  (mem_wr_s),
    .branch  (branch_s),
    .illegal (illegal_s),
    .imm     (imm_s)
  );

  assign rf_raddr1  = REG_AW'(raddr1_s);
  assign rf_raddr2  = REG_AW'(raddr2_s);
  assign in_ready   = ready_s;
  assign illegal_op = accept_s & illegal_s;

  // Handshake: load-use hazard, ready, accept and ID/EX update selection
  always_comb begin
    hazard_s = ex_valid & ex_mem_rd & in_valid &
               ((use1_s & (REG_AW'(raddr1_s) == ex_wb_addr)) |
                (use2_s & (REG_AW'(raddr2_s) == ex_wb_addr)));
    hold_s   = ex_valid & ~ex_ready;
    // rst_n gates ready so nothing is taken while reset is held
    ready_s  = rst_n & (~ex_valid | ex_ready) & ~hazard_s & ~flush;
    accept_s = in_valid & ready_s;
    load_s   = 1'b0;
    clear_s  = 1'b0;
    if (flush) begin
      clear_s = 1'b1;
    end else if (hold_s) begin
      clear_s = 1'b0;
    end else if (accept_s & ~illegal_s) begin
      load_s  = 1'b1;
    end else begin
      // hazard bubble, idle cycle, or accepted illegal op issued as a NOP
      clear_s = 1'b1;
    end
  end

  // Operand selection with R0 reading as zero on every port
  always_comb begin
    if (use1_s && (raddr1_s != {FIELD_W{1'b0}})) begin
      a_s = rf_rdata1;
    end else begin
      a_s = 16'h0000;
    end
    if (b_imm_s) begin
      b_s = imm_s;
    end else if (use2_s && (raddr2_s != {FIELD_W{1'b0}})) begin
      b_s = rf_rdata2;
    end else begin
      b_s = 16'h0000;
    end
    if (mem_wr_s && (raddr2_s != {FIELD_W{1'b0}})) begin
      sd_s = rf_rdata2;
    end else begin
      sd_s = 16'h0000;
    end
    wb_en_s = wb_s & (rd_s != {FIELD_W{1'b0}});
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_alu_cmd    <= ALU_NC;
      ex_a          <= 16'h0000;
      ex_b          <= 16'h0000;
      ex_store_data <= 16'h0000;
      ex_wb_en      <= 1'b0;
      ex_wb_addr    <= '0;
      ex_mem_rd     <= 1'b0;
      ex_mem_wr     <= 1'b0;
      ex_branch     <= 1'b0;
      ex_pc         <= '0;
    end else if (clear_s) begin
      ex_valid      <= 1'b0;
      ex_alu_cmd    <= ALU_NC;
      ex_a          <= 16'h0000;
      ex_b          <= 16'h0000;
      ex_store_data <= 16'h0000;
      ex_wb_en      <= 1'b0;
      ex_wb_addr    <= '0;
      ex_mem_rd     <= 1'b0;
      ex_mem_wr     <= 1'b0;
      ex_branch     <= 1'b0;
      ex_pc         <= '0;
    end else if (load_s) begin
      ex_valid      <= 1'b1;
      ex_alu_cmd    <= alu_cmd_s;
      ex_a          <= a_s;
      ex_b          <= b_s;
      ex_store_data <= sd_s;
      ex_wb_en      <= wb_en_s;
      ex_wb_addr    <= REG_AW'(rd_s);
      ex_mem_rd     <= mem_rd_s;
      ex_mem_wr     <= mem_wr_s;
      ex_branch     <= branch_s;
      ex_pc         <= in_pc;
    end
  end

endmodule
